// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the RAW-hazard scoreboard.
//   ADDR_W / DEPTH : register address width and number of tracked in-flight stages
//   sb_entry_t     : one scoreboard slot {vld, dst}
//   opcode_e + op_* helpers : operand-usage decode shared with the control unit
package hazard_pkg;

    localparam int ADDR_W = 3;
    localparam int NREGS  = 2 ** ADDR_W;
    localparam int DEPTH  = 3;   // entry0 = ID/EX, entry1 = EX/MEM, entry2 = MEM/WB

    typedef struct packed {
        logic              vld;
        logic [ADDR_W-1:0] dst;
    } sb_entry_t;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_NOT = 4'd1,
        OP_ADD = 4'd2,
        OP_LDM = 4'd3,
        OP_LDD = 4'd4,
        OP_STD = 4'd5
    } opcode_e;

    // Reads the src field (IF/ID[20:18]).
    function automatic logic op_uses_src(opcode_e op);
        return (op == OP_ADD) || (op == OP_LDD) || (op == OP_STD);
    endfunction

    // Reads the dst field (IF/ID[23:21]) as an operand.
    function automatic logic op_uses_dst(opcode_e op);
        return (op == OP_ADD) || (op == OP_NOT) || (op == OP_STD);
    endfunction

    // CU WB bit: writes the dst register.
    function automatic logic op_writes(opcode_e op);
        return (op == OP_ADD) || (op == OP_NOT) || (op == OP_LDM) || (op == OP_LDD);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// hazard_match: combinational lookup of one register address against the
// youngest WIN scoreboard entries.
//   sb_i   : scoreboard entries, index 0 = youngest (ID/EX)
//   addr_i : register address read by the decoding instruction
//   hit_o  : 1 when a valid in-window entry targets addr_i
module hazard_match
    import hazard_pkg::*;
#(
    parameter int WIN = DEPTH - 1
) (
    input  sb_entry_t [DEPTH-1:0] sb_i,
    input  logic [ADDR_W-1:0]     addr_i,
    output logic                  hit_o
);

    always_comb begin
        hit_o = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            // Entries past the window are already visible through the register file.
            if (k < WIN && sb_i[k].vld && sb_i[k].dst == addr_i)
                hit_o = 1'b1;
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: RAW-hazard controller beside the decode stage.
// Tracks destinations of in-flight writers and freezes PC/IF-ID (stall) while
// injecting an ID/EX bubble when the IF/ID instruction reads a pending register.
//   clk, reset (async, active low)
//   id_valid, id_src_addr, id_dst_addr, id_uses_src, id_uses_dst, id_writes : IF/ID decode
//   flush        : squash the IF/ID instruction this cycle
//   stall/bubble : combinational hazard outputs
//   stall_cycles : saturating count of stalled cycles
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int WB_BYPASS = 1,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_src_addr,
    input  logic [ADDR_W-1:0] id_dst_addr,
    input  logic              id_uses_src,
    input  logic              id_uses_dst,
    input  logic              id_writes,
    input  logic              flush,
    output logic              stall,
    output logic              bubble,
    output logic [CNT_W-1:0]  stall_cycles
);

    // With a write-before-read register file the MEM/WB entry is already readable.
    localparam int WIN = DEPTH - WB_BYPASS;

    sb_entry_t [DEPTH-1:0] sb_q, sb_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  src_hit, dst_hit, hazard;

    // Only older entries are searched, so an instruction never waits on itself.
    hazard_match #(.WIN(WIN)) u_src_match (
        .sb_i   (sb_q),
        .addr_i (id_src_addr),
        .hit_o  (src_hit)
    );

    hazard_match #(.WIN(WIN)) u_dst_match (
        .sb_i   (sb_q),
        .addr_i (id_dst_addr),
        .hit_o  (dst_hit)
    );

    always_comb begin
        // flush wins over hazard; reset forces the outputs low even mid-stall.
        hazard = reset & id_valid & ~flush &
                 ((id_uses_src & src_hit) | (id_uses_dst & dst_hit));

        // A stalled or flushed instruction enters ID/EX as a bubble (invalid entry).
        sb_d[0].vld = id_valid & id_writes & ~hazard & ~flush;
        sb_d[0].dst = id_dst_addr;
        for (int k = 1; k < DEPTH; k++)
            sb_d[k] = sb_q[k-1];

        cnt_d = cnt_q;
        if (hazard && cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb_q  <= '0;
            cnt_q <= '0;
        end else begin
            sb_q  <= sb_d;
            cnt_q <= cnt_d;
        end
    end

    assign stall        = hazard;
    assign bubble       = hazard;
    assign stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed instruction sequences, a cycle-numbered
// writer-list model checked every negedge, and literal expectations per scenario.
// A second instance with a 4-bit counter shares all inputs to exercise saturation.
module tb_hazard_scoreboard;

    localparam int WIN = 2;   // DEPTH 3 with write-before-read register file

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       id_valid = 1'b0;
    logic [2:0] id_src_addr = '0;
    logic [2:0] id_dst_addr = '0;
    logic       id_uses_src = 1'b0;
    logic       id_uses_dst = 1'b0;
    logic       id_writes = 1'b0;
    logic       flush = 1'b0;
    logic       stall, bubble, stall4, bubble4;
    logic [15:0] stall_cycles;
    logic [3:0]  sc4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.WB_BYPASS(1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_dst_addr(id_dst_addr), .id_uses_src(id_uses_src), .id_uses_dst(id_uses_dst),
        .id_writes(id_writes), .flush(flush), .stall(stall), .bubble(bubble),
        .stall_cycles(stall_cycles)
    );

    hazard_scoreboard #(.WB_BYPASS(1), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_dst_addr(id_dst_addr), .id_uses_src(id_uses_src), .id_uses_dst(id_uses_dst),
        .id_writes(id_writes), .flush(flush), .stall(stall4), .bubble(bubble4),
        .stall_cycles(sc4)
    );

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: writers remembered by the cycle they issued ----------------
    typedef struct { int cyc; int dst; } wr_t;
    wr_t wq[$];
    int  cyc = 0;
    int  m_cnt = 0;

    function automatic logic model_hazard();
        logic h;
        int   age;
        h = 1'b0;
        if (!reset || !id_valid || flush) return 1'b0;
        foreach (wq[i]) begin
            age = cyc - wq[i].cyc;   // 1 => writer now in ID/EX
            if (age >= 1 && age <= WIN &&
                ((id_uses_src && wq[i].dst == int'(id_src_addr)) ||
                 (id_uses_dst && wq[i].dst == int'(id_dst_addr))))
                h = 1'b1;
        end
        return h;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            wq.delete();
            m_cnt = 0;
            cyc = 0;
        end else begin
            logic h;
            wr_t  w;
            h = model_hazard();
            if (h && m_cnt < 65535) m_cnt++;
            if (id_valid && id_writes && !flush && !h) begin
                w.cyc = cyc;
                w.dst = int'(id_dst_addr);
                wq.push_back(w);
            end
            cyc++;
            while (wq.size() > 0 && cyc - wq[0].cyc > 4) void'(wq.pop_front());
        end
    end

    always @(negedge clk) begin
        logic h;
        h = model_hazard();
        chk("stall", stall, int'(h));
        chk("bubble", bubble, int'(h));
        chk("stall_cycles", stall_cycles, m_cnt);
        chk("stall4", stall4, int'(h));
        chk("bubble4", bubble4, int'(h));
        chk("stall_cycles4", sc4, (m_cnt > 15) ? 15 : m_cnt);
    end

    // ---------------- stimulus ----------------
    task automatic drv(input logic v, input int src, input int dst, input logic us,
                       input logic ud, input logic wr, input logic fl);
        id_valid = v; id_src_addr = 3'(src); id_dst_addr = 3'(dst);
        id_uses_src = us; id_uses_dst = ud; id_writes = wr; flush = fl;
    endtask

    task automatic nop();        drv(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0); endtask
    task automatic ldm(input int d); drv(1'b1, 0, d, 1'b0, 1'b0, 1'b1, 1'b0); endtask
    task automatic notr(input int d); drv(1'b1, 0, d, 1'b0, 1'b1, 1'b1, 1'b0); endtask
    task automatic nxt(); @(posedge clk); #1; endtask

    initial begin
        nop();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_bubble", bubble, 0);
        chk("rst_cnt", stall_cycles, 0);
        @(negedge clk); #1 reset = 1'b1;

        // idle: id_valid=0 never stalls
        nxt(); drv(1'b0, 3, 3, 1'b1, 1'b1, 1'b1, 1'b0); #1 chk("idle_no_stall", stall, 0);
        nxt(); nop();

        // LDM R0 ; ADD R7,R0 -> 2 stall cycles, issue in the third
        nxt(); ldm(0);
        nxt(); drv(1'b1, 0, 7, 1'b1, 1'b1, 1'b1, 1'b0);
        #1 chk("raw_stall1", stall, 1); chk("raw_bubble1", bubble, 1);
        nxt(); #1 chk("raw_stall2", stall, 1);
        nxt(); #1 chk("raw_issue", stall, 0); chk("raw_cnt", stall_cycles, 2);
        nxt(); nop();

        // same with two NOPs in between -> no stall
        nxt(); ldm(0);
        nxt(); nop();
        nxt(); nop();
        nxt(); drv(1'b1, 0, 7, 1'b1, 1'b1, 1'b1, 1'b0); #1 chk("nop_gap_no_stall", stall, 0);
        nxt(); nop();
        nxt(); nop();

        // LDM R7 ; LDM R7 ; NOT R7 -> waits for the younger writer
        nxt(); ldm(7);
        nxt(); ldm(7);
        nxt(); notr(7); #1 chk("b2b_stall1", stall, 1);
        nxt(); #1 chk("b2b_stall2", stall, 1);
        nxt(); #1 chk("b2b_issue", stall, 0); chk("b2b_cnt", stall_cycles, 4);
        nxt(); nop();
        nxt(); nop();

        // LDM R1 ; STD R1,R7 flushed ; ADD R2,R1 sees LDM only in EX/MEM
        nxt(); ldm(1);
        nxt(); drv(1'b1, 7, 1, 1'b1, 1'b1, 1'b0, 1'b1);
        #1 chk("flush_stall", stall, 0); chk("flush_bubble", bubble, 0);
        nxt(); drv(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0); #1 chk("flush_old_tracked", stall, 1);
        nxt(); #1 chk("flush_old_retired", stall, 0); chk("flush_cnt", stall_cycles, 5);

        // flushed writer never enters the scoreboard
        nxt(); drv(1'b1, 0, 3, 1'b0, 1'b0, 1'b1, 1'b1);
        nxt(); notr(3); #1 chk("flushed_writer", stall, 0);

        // flush beats a live hazard
        nxt(); ldm(4);
        nxt(); drv(1'b1, 0, 4, 1'b0, 1'b1, 1'b1, 1'b1); #1 chk("flush_prio", stall, 0);
        nxt(); notr(4); #1 chk("after_flush_stall", stall, 1);
        nxt(); #1 chk("after_flush_issue", stall, 0); chk("after_flush_cnt", stall_cycles, 6);
        nxt(); nop();

        // reset asserted mid-stall
        nxt(); ldm(5);
        nxt(); notr(5); #1 chk("pre_rst_stall", stall, 1);
        #1 reset = 1'b0;
        #1 chk("mid_rst_stall", stall, 0); chk("mid_rst_cnt", stall_cycles, 0);
        @(negedge clk); #1 reset = 1'b1;
        nxt(); nop();

        // 12 x (LDM R5 ; NOT R5) = 24 stall cycles; 4-bit counter pins at 15
        for (int i = 0; i < 12; i++) begin
            nxt(); ldm(5);
            nxt(); notr(5);
            nxt();
            nxt();
        end
        nxt(); nop();
        #1 chk("cnt16_total", stall_cycles, 24);
        chk("cnt4_saturated", sc4, 15);

        nxt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
